// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Multicycle execute unit. Decodes ALUOp/funct3/funct7 and produces
//   ALUResult plus the Zero and illegal flags. Logic, add/sub and compare
//   ops finish in one cycle. Shifts run on an iterative shifter that moves
//   SHIFT_STEP bits per cycle. The optional MUL is a shift-add multiplier
//   that returns the low word.
//
// Handshake (start/done):
//   start is sampled only while the unit is in IDLE or DONE. A start seen
//   there is "accepted": the operands and decode fields are captured on
//   that clock edge. busy is high while a multicycle op runs, and start is
//   ignored during that time. done is high for exactly one cycle.
//   ALUResult, Zero and illegal change only on the edge that enters DONE,
//   and they hold until the next accepted op completes. Holding start high
//   while in DONE launches the next op back-to-back.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 launch request
//   ALUOp                 00 add, 01 sub, 10 decode funct fields, 11 illegal
//   funct3, funct7b5      instruction funct fields
//   funct7b0              M-extension select (instr[25])
//   opb5                  op[5], 1 = R-type
//   SrcA, SrcB            operands (XLEN)
//   busy                  multicycle op in progress
//   done                  one-cycle completion pulse
//   ALUResult             result (XLEN)
//   Zero                  ALUResult == 0
//   illegal               unsupported encoding
//   dbg_state_o           current FSM state (IDLE=0, SHIFT=1, MUL=2, DONE=3)
module alu_seq_unit #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1,
  parameter int MUL_EN     = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      ALUOp,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            funct7b0,
  input  logic            opb5,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero,
  output logic            illegal,
  output logic [1:0]      dbg_state_o
);

  localparam int SHAMT_W = $clog2(XLEN);
  // Wide enough to hold XLEN itself, which is the multiply step count.
  localparam int CNT_W   = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
  } op_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;        // shift operand / multiplicand
  logic [XLEN-1:0]   b_q, b_d;        // multiplier
  logic [XLEN-1:0]   acc_q, acc_d;    // product accumulator
  logic [CNT_W-1:0]  cnt_q, cnt_d;    // shift bits left / multiply steps left
  logic              left_q, left_d;
  logic              sra_q, sra_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  op_t               op;
  logic [XLEN-1:0]   sc_res;
  logic              slt_s, slt_u;
  logic [SHAMT_W-1:0] shamt;
  logic              is_shift;
  logic [CNT_W-1:0]  step_amt;
  logic [XLEN-1:0]   sra_val;
  logic [XLEN-1:0]   shift_val;
  logic [XLEN-1:0]   mul_sum;

  // Decode
  always_comb begin
    op = OP_ILL;
    unique case (ALUOp)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        if (opb5 && funct7b0) begin
          // M-extension space: only MUL (funct3=000) exists here
          op = (funct3 == 3'b000 && MUL_EN != 0) ? OP_MUL : OP_ILL;
        end else begin
          unique case (funct3)
            3'b000: op = (funct7b5 && opb5) ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = funct7b5 ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
            default: op = OP_ILL;
          endcase
        end
      end
      default: op = OP_ILL;
    endcase
  end

  assign slt_s    = $signed(SrcA) < $signed(SrcB);
  assign slt_u    = SrcA < SrcB;
  assign shamt    = SrcB[SHAMT_W-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // Single-cycle result. A shift only takes this path when shamt is 0,
  // so returning SrcA unchanged for shifts is correct here.
  always_comb begin
    sc_res = '0;
    case (op)
      OP_ADD:  sc_res = SrcA + SrcB;
      OP_SUB:  sc_res = SrcA - SrcB;
      OP_SLT:  sc_res = {{(XLEN-1){1'b0}}, slt_s};
      OP_SLTU: sc_res = {{(XLEN-1){1'b0}}, slt_u};
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_AND:  sc_res = SrcA & SrcB;
      OP_SLL, OP_SRL, OP_SRA: sc_res = SrcA;
      default: sc_res = '0;
    endcase
  end

  // Iterative shifter: one step of min(SHIFT_STEP, remaining) bits.
  // The arithmetic shift is kept in its own signal so the signed operand
  // is not turned unsigned by a surrounding expression.
  assign step_amt = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  assign sra_val  = $signed(a_q) >>> step_amt;

  always_comb begin
    shift_val = a_q >> step_amt;
    if (left_q)     shift_val = a_q << step_amt;
    else if (sra_q) shift_val = sra_val;
  end

  assign mul_sum = acc_q + (b_q[0] ? a_q : '0);

  // Next state
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    sra_d     = sra_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (op == OP_MUL) begin
            state_d = S_MUL;
            a_d     = SrcA;
            b_d     = SrcB;
            acc_d   = '0;
            cnt_d   = CNT_W'(XLEN);
          end else if (is_shift && shamt != '0) begin
            state_d = S_SHIFT;
            a_d     = SrcA;
            cnt_d   = {1'b0, shamt};
            left_d  = (op == OP_SLL);
            sra_d   = (op == OP_SRA);
          end else begin
            state_d   = S_DONE;
            result_d  = sc_res;
            zero_d    = (sc_res == '0);
            illegal_d = (op == OP_ILL);
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        a_d   = shift_val;
        cnt_d = cnt_q - step_amt;
        if (cnt_q == step_amt) begin
          state_d   = S_DONE;
          result_d  = shift_val;
          zero_d    = (shift_val == '0);
          illegal_d = 1'b0;
        end
      end

      S_MUL: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d   = S_DONE;
          result_d  = mul_sum;
          zero_d    = (mul_sum == '0);
          illegal_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      sra_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      sra_q     <= sra_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy        = (state_q == S_SHIFT) || (state_q == S_MUL);
  assign done        = (state_q == S_DONE);
  assign ALUResult   = result_q;
  assign Zero        = zero_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit. Two instances share every input:
// dut_a uses the default parameters (SHIFT_STEP=1, MUL_EN=1), and
// dut_b uses SHIFT_STEP=8, MUL_EN=0.
module tb_alu_seq_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        f7b5, f7b0, opb5;
  logic [31:0] src_a, src_b;

  logic        busy_a, done_a, zero_a, ill_a;
  logic [31:0] res_a;
  logic [1:0]  dbg_a;
  logic        busy_b, done_b, zero_b, ill_b;
  logic [31:0] res_b;
  logic [1:0]  dbg_b;

  alu_seq_unit #(.XLEN(32), .SHIFT_STEP(1), .MUL_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .funct3(funct3),
    .funct7b5(f7b5), .funct7b0(f7b0), .opb5(opb5), .SrcA(src_a), .SrcB(src_b),
    .busy(busy_a), .done(done_a), .ALUResult(res_a), .Zero(zero_a),
    .illegal(ill_a), .dbg_state_o(dbg_a)
  );

  alu_seq_unit #(.XLEN(32), .SHIFT_STEP(8), .MUL_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUOp(alu_op), .funct3(funct3),
    .funct7b5(f7b5), .funct7b0(f7b0), .opb5(opb5), .SrcA(src_a), .SrcB(src_b),
    .busy(busy_b), .done(done_b), .ALUResult(res_b), .Zero(zero_b),
    .illegal(ill_b), .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          lat_a, lat_b, busy_cnt;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [1:0] op, input logic [2:0] f3,
                        input logic b5, input logic b0, input logic r,
                        input logic [31:0] a, input logic [31:0] b);
    alu_op = op; funct3 = f3; f7b5 = b5; f7b0 = b0; opb5 = r;
    src_a = a; src_b = b;
  endtask

  // Pulse start for one cycle from a negedge, then count negedges until
  // each instance shows done (cycle 1 = first negedge after the accept edge).
  // When poke > 0, start is pulsed again at that cycle with a different SrcA.
  task automatic run_op(input int poke);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat_a = 0; lat_b = 0; busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (poke > 0 && c == poke) begin
        start = 1'b1;
        src_a = 32'h7;
      end
      if (poke > 0 && c == poke + 1) start = 1'b0;
      if (busy_a) busy_cnt++;
      if (done_a && lat_a == 0) lat_a = c;
      if (done_b && lat_b == 0) lat_b = c;
      if (lat_a != 0 && lat_b != 0) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  // Both instances are expected to return the same legal result.
  task automatic expect_op(input string tag, input logic [31:0] res,
                           input int la, input int lb);
    logic [31:0] e;
    exp_q.push_back(res);
    e = exp_q.pop_front();
    chk({tag, "_res_a"}, res_a, e);
    chk({tag, "_res_b"}, res_b, e);
    chk({tag, "_zero_a"}, zero_a, (e == 32'h0));
    chk({tag, "_ill_a"}, ill_a, 1'b0);
    chk({tag, "_lat_a"}, lat_a, la);
    chk({tag, "_lat_b"}, lat_b, lb);
  endtask

  // ---------------- stimulus ----------------
  logic seen_done;

  initial begin
    rst_n = 1'b0; start = 1'b0;
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_res", res_a, 32'h0);
    chk("rst_zero", zero_a, 1'b0);
    chk("rst_ill", ill_a, 1'b0);
    chk("rst_state", dbg_a, 2'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // R-type sub: 5 - 7
    set_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7);
    run_op(0);
    expect_op("sub", 32'hFFFF_FFFE, 1, 1);

    // add wrapping to zero
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
    run_op(0);
    expect_op("add_wrap", 32'h0, 1, 1);

    // signed vs unsigned compare of -1 and 1
    set_op(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1);
    run_op(0);
    expect_op("slt", 32'h1, 1, 1);
    set_op(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1);
    run_op(0);
    expect_op("sltu", 32'h0, 1, 1);

    set_op(2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hFF00_FF00, 32'h0FF0_0FF0);
    run_op(0);
    expect_op("and", 32'h0F00_0F00, 1, 1);

    // sra by 31: step 1 -> 31 busy cycles; step 8 -> 8+8+8+7
    set_op(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd31);
    run_op(0);
    expect_op("sra31", 32'hFFFF_FFFF, 32, 5);
    chk("sra31_busy_a", busy_cnt, 31);

    set_op(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h1, 32'd4);
    run_op(0);
    expect_op("sll4", 32'h10, 5, 2);

    set_op(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'hF000_0000, 32'd12);
    run_op(0);
    expect_op("srl12", 32'h000F_0000, 13, 3);

    // shamt field is zero (upper SrcB bits ignored): single-cycle path
    set_op(2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h20);
    run_op(0);
    expect_op("sll0", 32'h1234, 1, 1);

    // mul FFFFFFFF*3 with a stray start (new SrcA) at cycle 10
    set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd3);
    run_op(10);
    chk("mul_res_a", res_a, 32'hFFFF_FFFD);
    chk("mul_lat_a", lat_a, 33);
    chk("mul_ill_a", ill_a, 1'b0);
    chk("mul_ill_b", ill_b, 1'b1);
    chk("mul_res_b", res_b, 32'h0);
    chk("mul_zero_b", zero_b, 1'b1);
    chk("mul_lat_b", lat_b, 1);

    set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7);
    run_op(0);
    chk("mul67_res_a", res_a, 32'd42);
    chk("mul67_lat_a", lat_a, 33);

    // ALUOp=11 illegal
    set_op(2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 32'h55, 32'h66);
    run_op(0);
    chk("ill_res_a", res_a, 32'h0);
    chk("ill_zero_a", zero_a, 1'b1);
    chk("ill_flag_a", ill_a, 1'b1);
    chk("ill_flag_b", ill_b, 1'b1);
    chk("ill_lat_a", lat_a, 1);

    // M-space funct3 other than 000 is illegal even with MUL_EN=1
    set_op(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 32'h55, 32'h66);
    run_op(0);
    chk("mdiv_ill_a", ill_a, 1'b1);
    chk("mdiv_lat_a", lat_a, 1);

    // nonzero result ahead of the reset test
    set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 32'h100, 32'h23);
    run_op(0);
    expect_op("add123", 32'h123, 1, 1);

    // reset during MUL cycle 10
    set_op(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mul_busy_c10", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_done", done_a, 1'b0);
    chk("arst_res", res_a, 32'h0);
    chk("arst_state", dbg_a, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_a || done_b) seen_done = 1'b1;
    end
    chk("arst_no_done", seen_done, 1'b0);

    set_op(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2);
    run_op(0);
    expect_op("sltu12", 32'h1, 1, 1);

    // back-to-back: start held through DONE
    set_op(2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'h0000_F0F0, 32'h0000_0FF0);
    start = 1'b1;
    @(negedge clk);
    chk("b2b_xor_done", done_a, 1'b1);
    chk("b2b_xor_res_a", res_a, 32'h0000_FF00);
    chk("b2b_xor_res_b", res_b, 32'h0000_FF00);
    set_op(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'h0000_1200, 32'h0000_0034);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_or_done", done_a, 1'b1);
    chk("b2b_or_res_a", res_a, 32'h0000_1234);
    chk("b2b_or_res_b", res_b, 32'h0000_1234);
    @(negedge clk);
    chk("b2b_idle_done", done_a, 1'b0);
    chk("b2b_idle_state", dbg_a, 2'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want finish before it");
    $fatal(1);
  end

endmodule
